// File: rtl/adder_share_ctrl_pkg.sv
// Shared types and constants for the adder-sharing controller.
package adder_share_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_CFG,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [2:0] DES_ADDR_CTRL   = 3'd0;
  localparam logic [2:0] DES_ADDR_OFFSET = 3'd1;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_share_ctrl_if.sv
// Requester-side bus: operand requests in, results out.
// Operand slices are packed 8 bits per requester, slice i = requester i.
interface adder_share_ctrl_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [7:0]        rsp_sum;
  logic              rsp_carry;
  logic              rsp_err;

  // Client side.
  modport master (
    output req_valid, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_err
  );

  // Controller side.
  modport slave (
    input  req_valid, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_carry, rsp_err
  );
endinterface

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Round-robin grant: first set request bit at or after ptr, wrapping.
module adder_share_ctrl_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDXW = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            any
);

  logic [NREQ-1:0] scan;
  logic [IDXW:0]   pos;

  // Rotate so ptr lands at bit 0, then take the lowest set bit and map it back.
  always_comb begin
    scan      = NREQ'({req, req} >> ptr);
    pos       = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!any && scan[0]) begin
        pos = {1'b0, ptr} + (IDXW+1)'(k);
        if (pos >= (IDXW+1)'(NREQ)) begin
          pos = pos - (IDXW+1)'(NREQ);
        end
        grant_idx = pos[IDXW-1:0];
        any       = 1'b1;
      end
      scan = scan >> 1;
    end
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
    assign grant[gi] = any && (grant_idx == IDXW'(gi));
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Owns a single 8-bit adder: programs its control register once after reset,
// then serves one round-robin-selected requester at a time, returning the
// sum/carry or a timeout error.
module adder_share_ctrl
  import adder_share_ctrl_pkg::*;
#(
  parameter int         NREQ     = 2,
  parameter logic [7:0] CFG_CTRL = 8'h01,
  parameter int         TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                reset,
  adder_share_ctrl_if.slave   req_bus,
  output logic                cfg_done,
  output logic                dut_data_val,
  output logic [7:0]          dut_value_a,
  output logic [7:0]          dut_value_b,
  output logic                dut_c_in,
  input  logic                dut_data_ready,
  input  logic [7:0]          dut_sum,
  input  logic                dut_carry,
  output logic                dut_des_req_valid,
  output logic                dut_des_wr_rd,
  output logic [2:0]          dut_des_address,
  output logic [7:0]          dut_des_value
);

  localparam int IDXW = clog2_min1(NREQ);
  localparam int CW   = clog2_min1(TIMEOUT);

  state_t            state_reg;
  logic [IDXW-1:0]   rr_ptr_reg;
  logic [IDXW-1:0]   grant_idx_reg;
  logic [NREQ-1:0]   grant_oh_reg;
  logic [CW-1:0]     cnt_reg;
  logic              data_val_reg;
  logic [7:0]        a_reg;
  logic [7:0]        b_reg;
  logic              cin_reg;
  logic [NREQ-1:0]   rsp_valid_reg;
  logic [7:0]        rsp_sum_reg;
  logic              rsp_carry_reg;
  logic              rsp_err_reg;
  logic              cfg_done_reg;
  logic              des_valid_reg;
  logic              des_wr_reg;
  logic [2:0]        des_addr_reg;
  logic [7:0]        des_value_reg;

  logic [NREQ-1:0]   arb_grant;
  logic [IDXW-1:0]   arb_idx;
  logic              arb_any;

  adder_share_ctrl_rr_arbiter #(
    .NREQ (NREQ),
    .IDXW (IDXW)
  ) u_arb (
    .req       (req_bus.req_valid),
    .ptr       (rr_ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Accept is a same-cycle handshake, so req_ready follows the live grant in IDLE.
  assign req_bus.req_ready = (state_reg == ST_IDLE && !reset) ? arb_grant : '0;
  assign req_bus.rsp_valid = rsp_valid_reg;
  assign req_bus.rsp_sum   = rsp_sum_reg;
  assign req_bus.rsp_carry = rsp_carry_reg;
  assign req_bus.rsp_err   = rsp_err_reg;

  assign cfg_done          = cfg_done_reg;
  assign dut_data_val      = data_val_reg;
  assign dut_value_a       = a_reg;
  assign dut_value_b       = b_reg;
  assign dut_c_in          = cin_reg;
  assign dut_des_req_valid = des_valid_reg;
  assign dut_des_wr_rd     = des_wr_reg;
  assign dut_des_address   = des_addr_reg;
  assign dut_des_value     = des_value_reg;

  // Controller FSM. CFG spends one cycle loading the Des write registers and
  // one cycle presenting them, so the write is visible for exactly one cycle
  // and IDLE starts with cfg_done already high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_CFG;
      rr_ptr_reg    <= '0;
      grant_idx_reg <= '0;
      grant_oh_reg  <= '0;
      cnt_reg       <= '0;
      data_val_reg  <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      cin_reg       <= 1'b0;
      rsp_valid_reg <= '0;
      rsp_sum_reg   <= '0;
      rsp_carry_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      cfg_done_reg  <= 1'b0;
      des_valid_reg <= 1'b0;
      des_wr_reg    <= 1'b0;
      des_addr_reg  <= '0;
      des_value_reg <= '0;
    end else begin
      case (state_reg)
        ST_CFG: begin
          if (!des_valid_reg) begin
            des_valid_reg <= 1'b1;
            des_wr_reg    <= 1'b1;
            des_addr_reg  <= DES_ADDR_CTRL;
            des_value_reg <= CFG_CTRL;
          end else begin
            des_valid_reg <= 1'b0;
            des_wr_reg    <= 1'b0;
            des_addr_reg  <= '0;
            des_value_reg <= '0;
            cfg_done_reg  <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (arb_any) begin
            grant_idx_reg <= arb_idx;
            grant_oh_reg  <= arb_grant;
            a_reg         <= req_bus.req_a[{arb_idx, 3'b000} +: 8];
            b_reg         <= req_bus.req_b[{arb_idx, 3'b000} +: 8];
            cin_reg       <= req_bus.req_cin[arb_idx];
            data_val_reg  <= 1'b1;
            state_reg     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          data_val_reg <= 1'b0;
          cnt_reg      <= '0;
          state_reg    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dut_data_ready) begin
            rsp_sum_reg   <= dut_sum;
            rsp_carry_reg <= dut_carry;
            rsp_err_reg   <= 1'b0;
            rsp_valid_reg <= grant_oh_reg;
            state_reg     <= ST_RESP;
          end else if (cnt_reg == CW'(TIMEOUT - 1)) begin
            rsp_sum_reg   <= '0;
            rsp_carry_reg <= 1'b0;
            rsp_err_reg   <= 1'b1;
            rsp_valid_reg <= grant_oh_reg;
            state_reg     <= ST_RESP;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        ST_RESP: begin
          // Only the winner's rsp_ready retires the response.
          if (|(req_bus.rsp_ready & grant_oh_reg)) begin
            rsp_valid_reg <= '0;
            rsp_sum_reg   <= '0;
            rsp_carry_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            if (grant_idx_reg == IDXW'(NREQ - 1)) begin
              rr_ptr_reg <= '0;
            end else begin
              rr_ptr_reg <= grant_idx_reg + IDXW'(1);
            end
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_CFG;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Self-checking bench for adder_share_ctrl with a behavioural adder model.
module tb_adder_share_ctrl;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adder_share_ctrl_if #(.NREQ(NREQ)) bus ();

  logic       cfg_done, dut_data_val, dut_c_in, dut_data_ready, dut_carry;
  logic       dut_des_req_valid, dut_des_wr_rd;
  logic [7:0] dut_value_a, dut_value_b, dut_sum, dut_des_value;
  logic [2:0] dut_des_address;

  adder_share_ctrl #(
    .NREQ     (NREQ),
    .CFG_CTRL (8'h01),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_bus           (bus),
    .cfg_done          (cfg_done),
    .dut_data_val      (dut_data_val),
    .dut_value_a       (dut_value_a),
    .dut_value_b       (dut_value_b),
    .dut_c_in          (dut_c_in),
    .dut_data_ready    (dut_data_ready),
    .dut_sum           (dut_sum),
    .dut_carry         (dut_carry),
    .dut_des_req_valid (dut_des_req_valid),
    .dut_des_wr_rd     (dut_des_wr_rd),
    .dut_des_address   (dut_des_address),
    .dut_des_value     (dut_des_value)
  );

  typedef struct {
    int         who;
    logic [7:0] sum;
    logic       carry;
    logic       err;
  } exp_t;

  typedef struct {
    int         who;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    int         lat;
    logic [7:0] exp_sum;
    logic       exp_carry;
    logic       exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;
  int   model_lat = 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({bus.req_ready, bus.rsp_valid, bus.rsp_sum, bus.rsp_carry, bus.rsp_err,
                cfg_done, dut_data_val, dut_value_a, dut_value_b, dut_c_in,
                dut_des_req_valid, dut_des_wr_rd, dut_des_address, dut_des_value});
  endfunction

  // Adder model: raises Data_ready for one cycle, model_lat cycles after the
  // Data_val cycle; model_lat <= 0 means it never answers.
  initial begin
    int cd;
    cd = 0;
    dut_data_ready = 1'b0;
    dut_sum = 8'h00;
    dut_carry = 1'b0;
    forever begin
      @(negedge clk);
      dut_data_ready = 1'b0;
      if (reset) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            dut_data_ready = 1'b1;
            {dut_carry, dut_sum} = {1'b0, dut_value_a} + {1'b0, dut_value_b} + {8'h00, dut_c_in};
          end
        end
        if (dut_data_val) cd = (model_lat > 0) ? model_lat : 0;
      end
    end
  end

  // Wait (bounded) until req_ready has a bit inside mask; called at a negedge.
  task automatic wait_ready(input logic [NREQ-1:0] mask, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      #1;
      if ((bus.req_ready & mask) != '0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_ready_wait actual=%0b required=any_of_%0b", bus.req_ready, mask);
    end
  endtask

  // Bounded wait for any rsp_valid; returns cycles counted.
  task automatic wait_rsp(output int k);
    k = 1;
    while (bus.rsp_valid == '0 && k < 40) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_cfg();
    int         des_cnt, des_first, done_first;
    logic [2:0] addr;
    logic [7:0] val;
    logic       wr;
    des_cnt = 0; des_first = -1; done_first = -1;
    addr = 3'h7; val = 8'hEE; wr = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (dut_des_req_valid) begin
        des_cnt++;
        if (des_first < 0) begin
          des_first = c;
          addr = dut_des_address;
          val = dut_des_value;
          wr = dut_des_wr_rd;
        end
      end
      if (cfg_done && done_first < 0) done_first = c;
    end
    check("cfg_des_cycles", 64'(des_cnt), 64'd1);
    check("cfg_des_addr", 64'(addr), 64'd0);
    check("cfg_des_value", 64'(val), 64'h01);
    check("cfg_des_wr", 64'(wr), 64'd1);
    check("cfg_done_next", 64'(done_first), 64'(des_first + 1));
    $display("cfg des_cycles=%0d addr=%0d value=%02h done_at=%0d", des_cnt, addr, val, done_first);
  endtask

  task automatic do_txn(input vec_t v);
    bit   ok;
    int   k, exp_k;
    exp_t e;
    model_lat = v.lat;
    bus.req_a[v.who*8 +: 8] = v.a;
    bus.req_b[v.who*8 +: 8] = v.b;
    bus.req_cin[v.who] = v.cin;
    bus.req_valid[v.who] = 1'b1;
    sb.push_back('{who: v.who, sum: v.exp_sum, carry: v.exp_carry, err: v.exp_err});
    wait_ready(NREQ'(1 << v.who), ok);
    if (!ok) begin
      bus.req_valid[v.who] = 1'b0;
      void'(sb.pop_front());
      return;
    end
    @(negedge clk);
    bus.req_valid[v.who] = 1'b0;
    wait_rsp(k);
    exp_k = (v.lat >= 1 && v.lat <= TIMEOUT) ? v.lat + 2 : TIMEOUT + 2;
    check("txn_latency", 64'(k), 64'(exp_k));
    e = sb.pop_front();
    check("txn_rsp_valid", 64'(bus.rsp_valid), 64'(1 << e.who));
    check("txn_sum", 64'(bus.rsp_sum), 64'(e.sum));
    check("txn_carry", 64'(bus.rsp_carry), 64'(e.carry));
    check("txn_err", 64'(bus.rsp_err), 64'(e.err));
    $display("txn who=%0d a=%02h b=%02h cin=%0d lat=%0d -> sum=%02h carry=%0d err=%0d cycles=%0d",
             v.who, v.a, v.b, v.cin, v.lat, bus.rsp_sum, bus.rsp_carry, bus.rsp_err, k);
    bus.rsp_ready[v.who] = 1'b1;
    @(negedge clk);
    bus.rsp_ready[v.who] = 1'b0;
    check("txn_rsp_drop", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   ok;
    exp_t e;
    int   g, k, stale;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = '0;

    //          who a      b      cin   lat sum    carry err
    vecs[0] = '{0, 8'hFF, 8'h07, 1'b0, 2,  8'h06, 1'b1, 1'b0};
    vecs[1] = '{1, 8'h12, 8'h34, 1'b1, 1,  8'h47, 1'b0, 1'b0};
    vecs[2] = '{0, 8'h80, 8'h80, 1'b0, 3,  8'h00, 1'b1, 1'b0};
    vecs[3] = '{1, 8'h01, 8'h01, 1'b0, 16, 8'h02, 1'b0, 1'b0};
    vecs[4] = '{0, 8'h03, 8'h04, 1'b0, 17, 8'h00, 1'b0, 1'b1};
    vecs[5] = '{1, 8'h0F, 8'hF0, 1'b1, 5,  8'h00, 1'b1, 1'b0};
    vecs[6] = '{0, 8'h11, 8'h22, 1'b0, -1, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{1, 8'h55, 8'h2A, 1'b0, 2,  8'h7F, 1'b0, 1'b0};

    // Reset state and the one-shot configuration write.
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 64'd0);
    reset = 1'b0;
    check_cfg();

    // Single-requester vectors, including the ready/timeout boundary.
    foreach (vecs[i]) do_txn(vecs[i]);

    // Both requesters always valid: grants must alternate starting at 0.
    model_lat = 1;
    bus.req_a = {8'h20, 8'h10};
    bus.req_b = {8'h02, 8'h01};
    bus.req_cin = '0;
    bus.req_valid = 2'b11;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{who: i % 2, sum: (i % 2 == 1) ? 8'h22 : 8'h11, carry: 1'b0, err: 1'b0});
    end
    for (int i = 0; i < 6; i++) begin
      wait_ready(2'b11, ok);
      if (!ok) break;
      g = bus.req_ready[1] ? 1 : 0;
      e = sb.pop_front();
      check("rr_grant", 64'(bus.req_ready), 64'(1 << e.who));
      @(negedge clk);
      wait_rsp(k);
      check("rr_sum", 64'(bus.rsp_sum), 64'(e.sum));
      $display("txn rr=%0d grant=%0d sum=%02h", i, g, bus.rsp_sum);
      bus.rsp_ready = bus.rsp_valid;
      @(negedge clk);
      bus.rsp_ready = '0;
    end
    bus.req_valid = '0;
    sb.delete();

    // Response back-pressure: data held, other index's rsp_ready ignored, no new accept.
    model_lat = 2;
    bus.req_a[7:0] = 8'h40;
    bus.req_b[7:0] = 8'h41;
    bus.req_cin[0] = 1'b1;
    bus.req_valid = 2'b01;
    sb.push_back('{who: 0, sum: 8'h82, carry: 1'b0, err: 1'b0});
    wait_ready(2'b01, ok);
    @(negedge clk);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b10;
    wait_rsp(k);
    e = sb.pop_front();
    for (int c = 0; c < 5; c++) begin
      check("bp_hold", 64'({bus.rsp_valid, bus.rsp_sum, bus.rsp_carry, bus.rsp_err, bus.req_ready}),
            64'({2'b01, e.sum, e.carry, e.err, 2'b00}));
      @(negedge clk);
    end
    $display("txn backpressure who=0 sum=%02h carry=%0d", bus.rsp_sum, bus.rsp_carry);
    bus.rsp_ready = 2'b01;
    bus.req_valid = '0;
    @(negedge clk);
    bus.rsp_ready = '0;
    check("bp_release", 64'(bus.rsp_valid), 64'd0);

    // Reset while waiting on the adder: everything clears, CFG reruns, no stale response.
    model_lat = -1;
    bus.req_a[15:8] = 8'h77;
    bus.req_b[15:8] = 8'h01;
    bus.req_valid = 2'b10;
    sb.push_back('{who: 1, sum: 8'h78, carry: 1'b0, err: 1'b0});
    wait_ready(2'b10, ok);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_outs", all_outs(), 64'd0);
    sb.delete();
    reset = 1'b0;
    $display("txn reset_during_wait aborted");
    check_cfg();
    stale = 0;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) stale++;
    end
    check("no_stale_rsp", 64'(stale), 64'd0);

    // Normal operation resumes after the reset.
    do_txn('{0, 8'hC8, 8'h64, 1'b1, 2, 8'h2D, 1'b1, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
